// File: rtl/reset_seq_unit.sv
// Power-on reset sequencer: qualifies PLL lock, holds all channels, then releases them one by one.
// Optional watchdog built when JX2_RESET_SEQ_WDT_EN is defined.
module reset_seq_unit #(
   parameter int unsigned NCH       = 6,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned INIT_CNT  = 16'hAA55,
   parameter int unsigned STAGE_GAP = 16,
   parameter int unsigned SW_HOLD   = 64,
   parameter int unsigned WDT_CYC   = 1 << 20
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           pllLocked,
   input  logic           swReset,
   input  logic           wdtKick,
   output logic [NCH-1:0] rstOut,
   output logic           seqDone,
   output logic [1:0]     seqState,
   output logic           wdtFired
);

   localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int unsigned HOLD_W = (SW_HOLD > 1) ? $clog2(SW_HOLD) : 1;

   localparam logic [CNT_W-1:0]  INIT_V    = CNT_W'(INIT_CNT);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SW_HOLD - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCH - 1);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_STAGE = 2'd1,
      ST_RUN   = 2'd2,
      ST_SWRST = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [NCH-1:0]    rst_out_q, rst_out_d;
   logic              seq_done_q, seq_done_d;
   logic              sync1_q, sync2_q;
   logic              lock_sync;
   logic              wdt_trip;

   assign lock_sync = sync2_q;

`ifdef JX2_RESET_SEQ_WDT_EN
   localparam int unsigned WDT_W = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             wdt_fired_q, wdt_fired_d;

   // A kick on the timeout cycle suppresses the trip.
   assign wdt_trip = (state_q == ST_RUN) && (wdt_cnt_q == WDT_LAST) && !wdtKick;
   assign wdtFired = wdt_fired_q;
`else
   logic unused_wdt;
   assign unused_wdt = wdtKick & (WDT_CYC != 0);
   assign wdt_trip   = 1'b0;
   assign wdtFired   = 1'b0;
`endif

   // State and datapath registers; board reset clears everything on the edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_HOLD;
         count_q     <= '0;
         gap_q       <= '0;
         idx_q       <= '0;
         hold_q      <= '0;
         rst_out_q   <= '1;
         seq_done_q  <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
`ifdef JX2_RESET_SEQ_WDT_EN
         wdt_cnt_q   <= '0;
         wdt_fired_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         gap_q       <= gap_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         rst_out_q   <= rst_out_d;
         seq_done_q  <= seq_done_d;
         sync1_q     <= pllLocked;
         sync2_q     <= sync1_q;
`ifdef JX2_RESET_SEQ_WDT_EN
         wdt_cnt_q   <= wdt_cnt_d;
         wdt_fired_q <= wdt_fired_d;
`endif
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      gap_d      = gap_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      rst_out_d  = rst_out_q;
      seq_done_d = seq_done_q;
`ifdef JX2_RESET_SEQ_WDT_EN
      wdt_fired_d = wdt_fired_q;
`endif

      if (state_q != ST_HOLD && !lock_sync) begin
         // Lock loss outranks software and watchdog requests.
         state_d    = ST_HOLD;
         count_d    = '0;
         gap_d      = '0;
         idx_d      = '0;
         rst_out_d  = '1;
         seq_done_d = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               rst_out_d  = '1;
               seq_done_d = 1'b0;
               if (!lock_sync) begin
                  count_d = '0;
               end else if (count_q == INIT_V) begin
                  state_d = ST_STAGE;
                  gap_d   = '0;
                  idx_d   = '0;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            ST_STAGE: begin
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  for (int k = 0; k < NCH; k++) begin
                     if (idx_q == IDX_W'(k)) rst_out_d[k] = 1'b0;
                  end
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_RUN;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            ST_RUN: begin
               rst_out_d  = '0;
               seq_done_d = 1'b1;
               if (swReset || wdt_trip) begin
                  state_d    = ST_SWRST;
                  rst_out_d  = '1;
                  seq_done_d = 1'b0;
                  gap_d      = '0;
                  hold_d     = '0;
`ifdef JX2_RESET_SEQ_WDT_EN
                  if (wdt_trip) wdt_fired_d = 1'b1;
`endif
               end
            end
            ST_SWRST: begin
               rst_out_d  = '1;
               seq_done_d = 1'b0;
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_STAGE;
                  gap_d   = '0;
                  idx_d   = '0;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: state_d = ST_HOLD;
         endcase
      end

`ifdef JX2_RESET_SEQ_WDT_EN
      // Counter only advances while staying in RUN; any exit or kick clears it.
      if (state_q == ST_RUN && state_d == ST_RUN && !wdtKick) begin
         wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end else begin
         wdt_cnt_d = '0;
      end
`endif
   end

   assign rstOut   = rst_out_q;
   assign seqDone  = seq_done_q;
   assign seqState = state_q;

endmodule
